hub75_fill_swap_ctrl: RTL
=========================

# hub75_fill_swap_ctrl

Bus-mapped controller that sequences the HUB75 panel driver's double-buffered framebuffer. It fills rectangles with a solid colour in the current back buffer by mastering the driver's bus port. It also performs tear-free buffer swaps: it clears the driver's vsync flag, polls until the flag sets again, then rewrites the driver's buffer-select bit. It sits between the CPU bus (slave side) and the `hub75_driver` bus port (master side).

## Interface
- `ROWS`, 64, panel rows; power of 2, ≤64.
- `COLS`, 64, panel columns; power of 2, ≤64.
- `BASEADDR`, 32'h81100000, base of this block's 3-word register window.
- `HUB_BASE`, 32'h81000000, base address of the driver; driver control word at `HUB_BASE + ROWS*COLS*8`.

Ports:
- `clk` in 1: single clock, shared with the driver's `clk`.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `addr` in 32, `wdata` in 32, `wmask` in 4, `wen` in 1, `ren` in 1: CPU slave request.
- `rdata` out 32, `ready` out 1, `active` out 1: CPU slave response; `active` is combinational address decode.
- `m_addr` out 32, `m_wdata` out 32, `m_wmask` out 4, `m_wen` out 1, `m_ren` out 1: master request to the driver.
- `m_rdata` in 32, `m_ready` in 1: driver response.
- `irq` out 1: one-cycle pulse when a fill or swap completes.

## Operation
Registers (word offsets):
- 0 CTRL
  - bit0 START (W1, self-clearing)
  - bit1 SWAP (W1)
  - bit2 BUSY (RO; fill active)
  - bit3 SWAP_PEND (RO)
  - bit4 FRONT (RO)
  - bit5 ERR (sticky; write 1 to clear)
- 1 RECT: `[5:0]` x0, `[13:8]` y0, `[21:16]` w-1, `[29:24]` h-1.
- 2 COLOR: `[23:0]` {B,G,R}.

Register rules:
- Writes honour `wmask` per byte.
- Reads return the current register value; unused bits read 0.
- START written while BUSY: start is ignored and ERR is set. RECT and COLOR writes during BUSY take effect at the next fill.
- SWAP written while SWAP_PEND: no effect.
- START and SWAP written in the same write: fill runs first, then the swap.

Back buffer is `back = ~FRONT`. Pixel (x,y) in buffer b is at driver word `{b, y, x}`:
- Byte address = `HUB_BASE + ({b,y,x} << 2)`.
- x field is log2(COLS) bits; y field is log2(ROWS) bits.

Clipping:
- Columns run x0..min(x0+w-1, COLS-1); rows run y0..min(y0+h-1, ROWS-1). Sums use 7 bits, so there is no wrap.
- x0 ≥ COLS or y0 ≥ ROWS: zero writes; fill completes immediately with `irq`.

Fill traversal is row-major with x as the inner loop. Every write uses `m_wmask=4'b0111` and `m_wdata={8'h0, COLOR}`.

Master FSM states: IDLE, F_REQ, F_GAP, S_CLR, S_GAP0, S_POLL, S_GAP1, S_SEL, S_GAP2.
- IDLE:
  - BUSY → F_REQ.
  - Otherwise SWAP_PEND → S_CLR.
  - Fill has priority over swap.
- F_REQ: assert `m_wen` until `m_ready` is sampled 1 → F_GAP. Advance x/y; on the last pixel clear BUSY and pulse `irq`.
- F_GAP: no request for 1 cycle, then → F_REQ if more pixels remain, else → IDLE.
- S_CLR: write the driver control word with `m_wmask=4'b0010`, `m_wdata[8]=1` (clears the stale vsync flag) → S_GAP0.
- S_GAP0: 1 idle cycle → S_POLL.
- S_POLL: `m_ren` to the control word; on `m_ready` check `m_rdata[8]`.
  - Bit set → S_GAP1 then S_SEL.
  - Bit clear → S_GAP0 and re-poll.
- S_SEL: write `m_wmask=4'b0001`, `m_wdata[0]=back`.
  - On `m_ready`: FRONT ← back, SWAP_PEND ← 0, pulse `irq`.
  - Then → S_GAP2 → IDLE.
- Master request outputs hold stable while a request is asserted. `m_ready` is ignored outside request states.

## Timing
- Reset values: `rdata`, `ready`, `m_*` request outputs, `irq`, CTRL, RECT, COLOR, FRONT all 0; FSM in IDLE.
- Slave `ready` is registered. It goes high the cycle after a cycle with `active & (wen|ren)`, mirroring the driver protocol. Read data is valid in the same cycle as `ready`.
- START → first `m_wen` asserts on the cycle after the CPU write's `ready`.
- The driver responds with 1-cycle latency, so each pixel costs 3 cycles (2 request cycles + gap). A full 64×64 fill takes 12288 cycles.
- `irq` is high for exactly 1 cycle, on the cycle after the completing handshake.
- Reset mid-operation: the FSM aborts immediately and drops the request. Written pixels are not rolled back. FRONT returns to 0, while the driver's select is not touched, so software must rewrite it.

## Test plan
- Fill RECT x0=2,y0=3,w-1=1,h-1=1, COLOR=0x00FF00, FRONT=0 → four writes: words `{1,3,2}`, `{1,3,3}`, `{1,4,2}`, `{1,4,3}`, data 0x00FF00, wmask 0111. One `irq` follows; BUSY falls.
- Fill x0=62, w-1=7 on a 64-wide panel → only x=62 and x=63 are written per row; no wrap to x=0.
- START during BUSY → ERR=1; the current fill is unaffected; writing 1 to bit5 clears ERR.
- SWAP with a driver model whose vsync sets 50 cycles later → clear write, repeated polls, select write `m_wdata[0]=1` only after `m_rdata[8]=1`. FRONT reads 1 afterward, with one `irq`.
- START+SWAP in one write → all fill writes complete before S_CLR; exactly 2 `irq` pulses.
- Assert `rst_n=0` mid-fill → all outputs 0 asynchronously. After release, CTRL reads 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/hub75_fill_swap_ctrl.sv
// Sequencer for the HUB75 driver's double-buffered framebuffer: solid rectangle
// fills into the back buffer and vsync-aligned front/back swaps, mastering the driver bus.
module hub75_fill_swap_ctrl #(
    parameter int          ROWS     = 64,
    parameter int          COLS     = 64,
    parameter logic [31:0] BASEADDR = 32'h81100000,
    parameter logic [31:0] HUB_BASE = 32'h81000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        active,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    output logic        m_wen,
    output logic        m_ren,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        irq
);
    localparam int          XW        = $clog2(COLS);
    localparam int          YW        = $clog2(ROWS);
    localparam logic [31:0] CTRL_ADDR = HUB_BASE + 32'(ROWS * COLS * 8);
    localparam logic [6:0]  X_MAX     = 7'(COLS - 1);
    localparam logic [6:0]  Y_MAX     = 7'(ROWS - 1);

    typedef enum logic [3:0] {
        IDLE, F_REQ, F_GAP, S_CLR, S_GAP0, S_POLL, S_GAP1, S_SEL, S_GAP2
    } state_t;

    state_t      state;
    logic        busy, swap_pend, front, err;
    logic [5:0]  rect_x0, rect_y0, rect_w, rect_h;
    logic [23:0] color;

    // Fill geometry is snapshotted at START so register writes during a fill only affect the next one.
    logic [6:0]  f_x0, f_xl, f_yl, cur_x, cur_y;
    logic [23:0] f_color;
    logic        f_empty;

    logic [31:0] offset;
    logic [1:0]  reg_sel;
    logic        wr, rd;
    logic [31:0] rd_val;
    logic [6:0]  x_end, y_end, x_last, y_last;
    logic        rect_empty;
    logic        unused_bits;

    function automatic logic [31:0] pix_addr(input logic b, input logic [YW-1:0] y,
                                             input logic [XW-1:0] x);
        logic [XW+YW:0] idx;
        idx = {b, y, x};
        return HUB_BASE + (32'(idx) << 2);
    endfunction

    assign offset  = addr - BASEADDR;
    assign active  = offset < 32'd12;
    assign reg_sel = offset[3:2];
    assign wr      = active & wen;
    assign rd      = active & ren;
    assign unused_bits = ^{offset[31:4], offset[1:0], wdata[31:30], m_rdata[31:9], m_rdata[7:0]};

    always_comb begin
        x_end      = {1'b0, rect_x0} + {1'b0, rect_w};
        y_end      = {1'b0, rect_y0} + {1'b0, rect_h};
        x_last     = (x_end > X_MAX) ? X_MAX : x_end;
        y_last     = (y_end > Y_MAX) ? Y_MAX : y_end;
        rect_empty = ({1'b0, rect_x0} > X_MAX) || ({1'b0, rect_y0} > Y_MAX);
        rd_val     = '0;
        case (reg_sel)
            2'd0:    rd_val = {26'd0, err, front, swap_pend, busy, 2'b00};
            2'd1:    rd_val = {2'b0, rect_h, 2'b0, rect_w, 2'b0, rect_y0, 2'b0, rect_x0};
            2'd2:    rd_val = {8'd0, color};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdata     <= '0;
            ready     <= 1'b0;
            irq       <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wmask   <= '0;
            m_wen     <= 1'b0;
            m_ren     <= 1'b0;
            busy      <= 1'b0;
            swap_pend <= 1'b0;
            front     <= 1'b0;
            err       <= 1'b0;
            rect_x0   <= '0;
            rect_y0   <= '0;
            rect_w    <= '0;
            rect_h    <= '0;
            color     <= '0;
            f_x0      <= '0;
            f_xl      <= '0;
            f_yl      <= '0;
            f_color   <= '0;
            f_empty   <= 1'b0;
            cur_x     <= '0;
            cur_y     <= '0;
        end else begin
            ready <= active & (wen | ren);
            rdata <= rd ? rd_val : '0;
            irq   <= 1'b0;

            if (wr) begin
                case (reg_sel)
                    2'd0: if (wmask[0]) begin
                        if (wdata[5]) err <= 1'b0;
                        if (wdata[0]) begin
                            if (busy) begin
                                err <= 1'b1;
                            end else begin
                                busy    <= 1'b1;
                                f_empty <= rect_empty;
                                f_x0    <= {1'b0, rect_x0};
                                f_xl    <= x_last;
                                f_yl    <= y_last;
                                f_color <= color;
                                cur_x   <= {1'b0, rect_x0};
                                cur_y   <= {1'b0, rect_y0};
                            end
                        end
                        if (wdata[1]) swap_pend <= 1'b1;
                    end
                    2'd1: begin
                        if (wmask[0]) rect_x0 <= wdata[5:0];
                        if (wmask[1]) rect_y0 <= wdata[13:8];
                        if (wmask[2]) rect_w  <= wdata[21:16];
                        if (wmask[3]) rect_h  <= wdata[29:24];
                    end
                    2'd2: begin
                        if (wmask[0]) color[7:0]   <= wdata[7:0];
                        if (wmask[1]) color[15:8]  <= wdata[15:8];
                        if (wmask[2]) color[23:16] <= wdata[23:16];
                    end
                    default: ;
                endcase
            end

            // Each request is followed by an idle cycle so the driver's stale ready never completes the next one.
            case (state)
                IDLE: begin
                    if (busy) begin
                        if (f_empty) begin
                            busy <= 1'b0;
                            irq  <= 1'b1;
                        end else begin
                            state   <= F_REQ;
                            m_wen   <= 1'b1;
                            m_addr  <= pix_addr(~front, cur_y[YW-1:0], cur_x[XW-1:0]);
                            m_wdata <= {8'd0, f_color};
                            m_wmask <= 4'b0111;
                        end
                    end else if (swap_pend) begin
                        state   <= S_CLR;
                        m_wen   <= 1'b1;
                        m_addr  <= CTRL_ADDR;
                        m_wdata <= 32'h0000_0100;
                        m_wmask <= 4'b0010;
                    end
                end
                F_REQ: if (m_ready) begin
                    m_wen <= 1'b0;
                    state <= F_GAP;
                    if (cur_x == f_xl) begin
                        cur_x <= f_x0;
                        if (cur_y == f_yl) begin
                            busy <= 1'b0;
                            irq  <= 1'b1;
                        end else begin
                            cur_y <= cur_y + 7'd1;
                        end
                    end else begin
                        cur_x <= cur_x + 7'd1;
                    end
                end
                F_GAP: begin
                    if (busy) begin
                        state  <= F_REQ;
                        m_wen  <= 1'b1;
                        m_addr <= pix_addr(~front, cur_y[YW-1:0], cur_x[XW-1:0]);
                    end else begin
                        state <= IDLE;
                    end
                end
                S_CLR: if (m_ready) begin
                    m_wen <= 1'b0;
                    state <= S_GAP0;
                end
                S_GAP0: begin
                    state   <= S_POLL;
                    m_ren   <= 1'b1;
                    m_addr  <= CTRL_ADDR;
                    m_wdata <= '0;
                    m_wmask <= '0;
                end
                S_POLL: if (m_ready) begin
                    m_ren <= 1'b0;
                    state <= m_rdata[8] ? S_GAP1 : S_GAP0;
                end
                S_GAP1: begin
                    state   <= S_SEL;
                    m_wen   <= 1'b1;
                    m_wdata <= {31'd0, ~front};
                    m_wmask <= 4'b0001;
                end
                S_SEL: if (m_ready) begin
                    m_wen     <= 1'b0;
                    front     <= ~front;
                    swap_pend <= 1'b0;
                    irq       <= 1'b1;
                    state     <= S_GAP2;
                end
                S_GAP2:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
